// File: rtl/la_rrarb5.sv
// ---------------------------------------------------------------------------
// la_rrarb5 -- five-requester round-robin arbiter with registered one-hot
// grant, intended to drive the select lines of a downstream 5-input one-hot
// mux (gnt[i] drives sel_i).
//
// Ports
//   clk     in   1  rising-edge clock for all state
//   nreset  in   1  asynchronous active-low reset (release sampled on clk)
//   en      in   1  arbitration enable; low forces an idle (no-grant) cycle
//   req     in   5  request vector, req[i] from requester i
//   gnt     out  5  registered one-hot grant vector (at most one bit high)
//   valid   out  1  registered, equals |gnt
//
// Parameters
//   PROP    cell property string, passed through, no effect on behaviour
//
// Build options
//   LA_RRARB5_LOCK_EN  when defined, a holder keeps its grant for as long as
//                      it keeps requesting (and en stays high). When
//                      undefined, arbitration re-runs every cycle and a
//                      continuously requesting holder yields to the next
//                      requester in round-robin order.
//
// Behaviour summary
//   * The search starts one past the last-grant pointer ptr and wraps 4->0.
//     ptr resets to 4, so the first search after reset starts at index 0.
//     A ptr value outside 0..4 also restarts the search at index 0.
//   * en low or no requests: next grant is empty, ptr holds.
//   * Reset clears gnt/valid immediately. Its release is sampled through a
//     one-flop run flag, so the first grant appears on the second rising
//     edge after nreset goes high.
// ---------------------------------------------------------------------------
module la_rrarb5 #(
  parameter PROP = "DEFAULT"
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       en,
  input  logic [4:0] req,
  output logic [4:0] gnt,
  output logic       valid
);

  localparam int          N         = 5;
  localparam logic [2:0]  PTR_RESET = 3'd4;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic       r_run;    // low for the first edge after reset release
  logic [2:0] r_ptr;    // index of the most recent grant (0..4)
  logic [4:0] r_gnt;
  logic       r_valid;

  // -------------------------------------------------------------------------
  // Combinational search
  // -------------------------------------------------------------------------
  logic [2:0] w_start;  // first index examined this cycle
  logic       w_found;  // some requester is asking
  logic [2:0] w_idx;    // winning index when w_found
  logic [4:0] w_onehot; // w_idx decoded to a one-hot grant
  logic       w_hold;   // current holder keeps its grant (lock build only)

  // Add an offset of 0..4 to a start index of 0..4 and wrap modulo 5.
  // The sum never exceeds 8, so a single conditional subtract is enough.
  function automatic logic [2:0] wrap5(input logic [2:0] base,
                                       input logic [2:0] off);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (sum >= 4'd5) begin
      sum = sum - 4'd5;
    end
    return sum[2:0];
  endfunction

  // Start one past the pointer. Pointer 4 wraps to 0, and an out-of-range
  // pointer (5..7) is treated the same way so a corrupted value recovers on
  // the very next grant.
  always_comb begin
    if (r_ptr >= PTR_RESET) begin
      w_start = 3'd0;
    end else begin
      w_start = r_ptr + 3'd1;
    end
  end

  // Walk the five indices in round-robin order and keep the first hit.
  // NOTE: every signal assigned in an always_comb gets a default at the top
  // of the block so that no path leaves it unassigned (which would infer a
  // latch).
  always_comb begin
    logic [2:0] cand;
    w_found = 1'b0;
    w_idx   = 3'd0;
    cand    = 3'd0;
    for (int off = 0; off < N; off++) begin
      cand = wrap5(w_start, 3'(off));
      if (!w_found && req[cand]) begin
        w_found = 1'b1;
        w_idx   = cand;
      end
    end
  end

  assign w_onehot = 5'd1 << w_idx;

`ifdef LA_RRARB5_LOCK_EN
  // The holder is whoever owns the registered grant and is still requesting.
  // en low is excluded here so that disabling always breaks the lock.
  assign w_hold = en & (|(r_gnt & req));
`else
  assign w_hold = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  // NOTE: all state is written with non-blocking assignments so that every
  // register samples the values from before this edge, regardless of the
  // order of statements or blocks.
  // NOTE: every register here is reset, including ptr; the arbiter has no
  // storage array, so there is nothing that could be left uninitialised.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_run   <= 1'b0;
      r_ptr   <= PTR_RESET;
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else if (!r_run) begin
      // First edge after release: arm the arbiter, keep the reset outputs.
      r_run   <= 1'b1;
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else if (!en || !w_found) begin
      // Idle: no grant and the pointer remembers the last winner.
      r_gnt   <= '0;
      r_valid <= 1'b0;
    end else if (w_hold) begin
      // Locked: grant and pointer already name the holder, so just keep them.
      r_gnt   <= r_gnt;
      r_valid <= 1'b1;
    end else begin
      r_gnt   <= w_onehot;
      r_valid <= 1'b1;
      r_ptr   <= w_idx;
    end
  end

  assign gnt   = r_gnt;
  assign valid = r_valid;

endmodule

// File: tb/tb_la_rrarb5.sv
// ---------------------------------------------------------------------------
// Self-checking bench for la_rrarb5. A behavioural model (integer pointer,
// integer grant index, modulo-5 search) predicts every grant. Directed
// scenarios cover reset, the round-robin sequence, requester drop, en
// toggling and reset asserted mid-grant; a randomized run cross-checks the
// model for 10k cycles with invariant and starvation checks.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_la_rrarb5;

  logic       clk;
  logic       nreset;
  logic       en;
  logic [4:0] req;
  logic [4:0] gnt;
  logic       valid;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  int m_ptr;    // last granted index
  int m_gnt;    // granted index, -1 when none
  bit m_armed;  // first edge after reset release has passed

  la_rrarb5 #(.PROP("DEFAULT")) dut (
    .clk    (clk),
    .nreset (nreset),
    .en     (en),
    .req    (req),
    .gnt    (gnt),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // -------------------------------------------------------------------------
  // Model
  // -------------------------------------------------------------------------
  function automatic void model_reset();
    m_ptr   = 4;
    m_gnt   = -1;
    m_armed = 1'b0;
  endfunction

  function automatic void model_step(input logic [4:0] r, input logic e);
    if (!m_armed) begin
      m_armed = 1'b1;
      m_gnt   = -1;
      return;
    end
    if (!e || r == 5'd0) begin
      m_gnt = -1;
      return;
    end
`ifdef LA_RRARB5_LOCK_EN
    if (m_gnt >= 0 && r[m_gnt]) return;
`endif
    for (int k = 1; k <= 5; k++) begin
      int idx;
      idx = (m_ptr + k) % 5;
      if (r[idx]) begin
        m_gnt = idx;
        m_ptr = idx;
        return;
      end
    end
  endfunction

  function automatic logic [4:0] model_vec();
    logic [4:0] v;
    v = 5'd0;
    if (m_gnt >= 0) v[m_gnt] = 1'b1;
    return v;
  endfunction

  // -------------------------------------------------------------------------
  // Stimulus helpers (no checking inside)
  // -------------------------------------------------------------------------
  task automatic cycle(input logic [4:0] r, input logic e);
    @(negedge clk);
    req = r;
    en  = e;
    @(posedge clk);
    model_step(r, e);
    #1;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    nreset = 1'b0;
    req    = 5'd0;
    en     = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
  endtask

  // Release reset on a falling edge with the given inputs, then step to
  // just after the next rising edge (which only arms the arbiter).
  task automatic release_reset(input logic [4:0] r, input logic e);
    @(negedge clk);
    nreset = 1'b1;
    req    = r;
    en     = e;
    @(posedge clk);
    model_step(r, e);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // Scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    logic [4:0] exp_seq [6];
`ifdef LA_RRARB5_LOCK_EN
    exp_seq = '{5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
`else
    exp_seq = '{5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001};
`endif
    hold_reset();
    checks++;
    if (gnt !== 5'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs gnt=%b valid=%b required gnt=00000 valid=0", gnt, valid);
    end
    checks++;
    if (dut.r_ptr !== 3'd4) begin
      errors++;
      $display("FAIL reset_ptr ptr=%0d required 4", dut.r_ptr);
    end
    release_reset(5'b11111, 1'b1);
    checks++;
    if (gnt !== 5'd0) begin
      errors++;
      $display("FAIL release_first_edge gnt=%b required 00000", gnt);
    end
    for (int i = 0; i < 6; i++) begin
      cycle(5'b11111, 1'b1);
      checks++;
      if (gnt !== exp_seq[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL all_req_seq[%0d] gnt=%b valid=%b required gnt=%b valid=1",
                 i, gnt, valid, exp_seq[i]);
      end
    end
  endtask

  task automatic test_drop();
    logic [4:0] exp_last;
`ifdef LA_RRARB5_LOCK_EN
    exp_last = 5'b10000;
`else
    exp_last = 5'b00001;
`endif
    hold_reset();
    release_reset(5'b00000, 1'b1);
    cycle(5'b10001, 1'b1);
    checks++;
    if (gnt !== 5'b00001) begin
      errors++;
      $display("FAIL drop_first gnt=%b required 00001", gnt);
    end
    cycle(5'b10000, 1'b1);
    checks++;
    if (gnt !== 5'b10000 || dut.r_ptr !== 3'd4) begin
      errors++;
      $display("FAIL drop_handover gnt=%b ptr=%0d required gnt=10000 ptr=4", gnt, dut.r_ptr);
    end
    cycle(5'b10001, 1'b1);
    checks++;
    if (gnt !== exp_last) begin
      errors++;
      $display("FAIL drop_wrap gnt=%b required %b", gnt, exp_last);
    end
  endtask

  task automatic test_en_toggle();
    hold_reset();
    release_reset(5'b00000, 1'b0);
    cycle(5'b01010, 1'b1);
    checks++;
    if (gnt !== 5'b00010 || dut.r_ptr !== 3'd1) begin
      errors++;
      $display("FAIL en_on gnt=%b ptr=%0d required gnt=00010 ptr=1", gnt, dut.r_ptr);
    end
    cycle(5'b01010, 1'b0);
    checks++;
    if (gnt !== 5'b00000 || valid !== 1'b0 || dut.r_ptr !== 3'd1) begin
      errors++;
      $display("FAIL en_off gnt=%b valid=%b ptr=%0d required gnt=00000 valid=0 ptr=1",
               gnt, valid, dut.r_ptr);
    end
    cycle(5'b01010, 1'b1);
    checks++;
    if (gnt !== 5'b01000 || dut.r_ptr !== 3'd3) begin
      errors++;
      $display("FAIL en_back gnt=%b ptr=%0d required gnt=01000 ptr=3", gnt, dut.r_ptr);
    end
  endtask

  task automatic test_reset_mid();
    hold_reset();
    release_reset(5'b00100, 1'b1);
    cycle(5'b00100, 1'b1);
    checks++;
    if (gnt !== 5'b00100) begin
      errors++;
      $display("FAIL mid_pre gnt=%b required 00100", gnt);
    end
    // Now 1ns after a rising edge; assert reset well before the next edge.
    #2;
    nreset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (gnt !== 5'd0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_async gnt=%b valid=%b required gnt=00000 valid=0", gnt, valid);
    end
    release_reset(5'b00100, 1'b1);
    checks++;
    if (gnt !== 5'd0) begin
      errors++;
      $display("FAIL mid_release_edge gnt=%b required 00000", gnt);
    end
    cycle(5'b00100, 1'b1);
    checks++;
    if (gnt !== 5'b00100) begin
      errors++;
      $display("FAIL mid_first_grant gnt=%b required 00100", gnt);
    end
  endtask

  task automatic test_random();
    logic [4:0] r;
    logic [4:0] mask;
    logic [4:0] exp;
    logic       e;
    int         wait_cnt [5];
    for (int i = 0; i < 5; i++) wait_cnt[i] = 0;
    hold_reset();
    release_reset(5'b00000, 1'b1);
    r = 5'd0;
    for (int n = 0; n < 10000; n++) begin
      mask = 5'd0;
      for (int b = 0; b < 5; b++) mask[b] = ($urandom_range(3) == 0);
      r = r ^ mask;
      e = ($urandom_range(7) != 0);
      cycle(r, e);
      exp = model_vec();
      checks++;
      if (gnt !== exp) begin
        errors++;
        $display("FAIL rand_gnt cycle=%0d req=%b en=%b gnt=%b required %b", n, r, e, gnt, exp);
      end
      checks++;
      if (valid !== (|exp) || valid !== (|gnt)) begin
        errors++;
        $display("FAIL rand_valid cycle=%0d valid=%b required %b", n, valid, |exp);
      end
      checks++;
      if (!$onehot0(gnt) || (gnt & ~r) != 5'd0) begin
        errors++;
        $display("FAIL rand_onehot_subset cycle=%0d gnt=%b req=%b", n, gnt, r);
      end
      checks++;
      if (dut.r_ptr > 3'd4 || int'(dut.r_ptr) != m_ptr) begin
        errors++;
        $display("FAIL rand_ptr cycle=%0d ptr=%0d required %0d", n, dut.r_ptr, m_ptr);
      end
`ifndef LA_RRARB5_LOCK_EN
      for (int i = 0; i < 5; i++) begin
        if (r[i] && e) begin
          if (gnt[i]) wait_cnt[i] = 0;
          else        wait_cnt[i]++;
          checks++;
          if (wait_cnt[i] > 4) begin
            errors++;
            $display("FAIL rand_starve cycle=%0d requester=%0d waited=%0d required at most 4",
                     n, i, wait_cnt[i]);
          end
        end else begin
          wait_cnt[i] = 0;
        end
      end
`endif
    end
  endtask

  initial begin
    nreset = 1'b0;
    req    = 5'd0;
    en     = 1'b0;
    model_reset();
    #2;
    test_reset();
    test_drop();
    test_en_toggle();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
